// File: rtl/vend_controller.sv
// vend_controller -- coin-operated vending machine controller.
//
// Accepts coins into a credit register, lets the customer pick a priced,
// stocked slot, hands the dispenser a request and pays back any remaining
// credit one coin at a time through the change hopper.
//
// Optional build macro: VEND_TIMEOUT_EN
//   When defined, TIMEOUT_CYC consecutive CREDIT cycles with no coin,
//   selection or cancel strobe refund the credit.
//   When undefined, no inactivity counter exists.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   coin_valid, coin_code      coin insert strobe and code
//                              (0=5, 1=10, 2=25, 3=50, 4=100, 5=500 cents)
//   sel_valid, sel_idx         slot selection strobe
//   cancel                     refund request strobe
//   cfg_we, restock, cfg_idx,  price write / stock reload of one slot,
//   cfg_price                  honoured only in IDLE
//   vend_valid/idx/ready       dispense handshake
//   chg_valid/code/ready       change-coin handshake
//   credit                     current credit in cents
//   avail, oos                 per-slot purchasable / out-of-service flags
//   coin_rej, sel_deny         one-cycle refusal pulses
//   busy                       high while dispensing or paying change
module vend_controller #(
    parameter int N_ITEMS     = 9,
    parameter int CENTS_W     = 10,
    parameter int MAX_CREDIT  = 500,
    parameter int STOCK_W     = 4,
    parameter int STOCK_INIT  = 8,
    parameter int TIMEOUT_CYC = 1000000,
    localparam int IW = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               coin_valid,
    input  logic [2:0]         coin_code,
    input  logic               sel_valid,
    input  logic [IW-1:0]      sel_idx,
    input  logic               cancel,
    input  logic               cfg_we,
    input  logic               restock,
    input  logic [IW-1:0]      cfg_idx,
    input  logic [CENTS_W-1:0] cfg_price,
    output logic               vend_valid,
    output logic [IW-1:0]      vend_idx,
    input  logic               vend_ready,
    output logic               chg_valid,
    output logic [2:0]         chg_code,
    input  logic               chg_ready,
    output logic [CENTS_W-1:0] credit,
    output logic [N_ITEMS-1:0] avail,
    output logic [N_ITEMS-1:0] oos,
    output logic               coin_rej,
    output logic               sel_deny,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

    state_t state, state_nx;

    logic [CENTS_W-1:0] price [N_ITEMS];
    logic [STOCK_W-1:0] stock [N_ITEMS];

    logic [CENTS_W-1:0] credit_nx;
    logic [IW-1:0]      vend_idx_nx;
    logic               coin_rej_nx, sel_deny_nx;
    logic               vend_done, cfg_ok;

    logic [CENTS_W:0]   coin_val, coin_sum;
    logic               code_ok, coin_take;
    logic               sel_hit, sel_take;
    logic [CENTS_W-1:0] sel_price;
    logic [CENTS_W-1:0] chg_val;
    logic               activity, timeout;

    assign activity = coin_valid || sel_valid || cancel;

    // ------------------------------------------------------------------
    // Inactivity timeout (optional)
    // ------------------------------------------------------------------
`ifdef VEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] idle_cnt;

    // Fires on the TIMEOUT_CYC-th quiet CREDIT cycle so the FSM is in
    // CHANGE right after that many quiet clocks.
    assign timeout = (state == CREDIT) && !activity &&
                     (idle_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_cnt <= '0;
        else if (state != CREDIT || activity || timeout)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + TW'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Decodes of registered state
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < N_ITEMS; i++) begin
            oos[i]   = (price[i] == '0) || (stock[i] == '0);
            avail[i] = (price[i] != '0) && (stock[i] != '0) && (credit >= price[i]);
        end
    end

    assign vend_valid = (state == VEND);
    assign busy       = (state == VEND) || (state == CHANGE);
    // Coins are multiples of 5, so a sub-nickel remainder cannot be paid.
    assign chg_valid  = (state == CHANGE) && (credit >= CENTS_W'(5));

    // Greedy change coin: largest denomination not above the credit.
    always_comb begin
        chg_code = 3'd0;
        chg_val  = CENTS_W'(5);
        if (credit >= CENTS_W'(100)) begin
            chg_code = 3'd4; chg_val = CENTS_W'(100);
        end else if (credit >= CENTS_W'(50)) begin
            chg_code = 3'd3; chg_val = CENTS_W'(50);
        end else if (credit >= CENTS_W'(25)) begin
            chg_code = 3'd2; chg_val = CENTS_W'(25);
        end else if (credit >= CENTS_W'(10)) begin
            chg_code = 3'd1; chg_val = CENTS_W'(10);
        end
    end

    always_comb begin
        code_ok  = 1'b1;
        coin_val = '0;
        case (coin_code)
            3'd0:    coin_val = (CENTS_W+1)'(5);
            3'd1:    coin_val = (CENTS_W+1)'(10);
            3'd2:    coin_val = (CENTS_W+1)'(25);
            3'd3:    coin_val = (CENTS_W+1)'(50);
            3'd4:    coin_val = (CENTS_W+1)'(100);
            3'd5:    coin_val = (CENTS_W+1)'(500);
            default: code_ok  = 1'b0;
        endcase
    end

    // Selection lookup without indexing past N_ITEMS.
    always_comb begin
        sel_hit   = 1'b0;
        sel_price = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (sel_idx == IW'(i)) begin
                sel_hit   = avail[i];
                sel_price = price[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Priority cancel > selection > coin: a coin arriving
    // alongside either other strobe is refused, whatever the state.
    // ------------------------------------------------------------------
    always_comb begin
        state_nx    = state;
        credit_nx   = credit;
        vend_idx_nx = vend_idx;
        vend_done   = 1'b0;
        cfg_ok      = 1'b0;

        coin_sum  = {1'b0, credit} + coin_val;
        coin_take = coin_valid && !cancel && !sel_valid && code_ok &&
                    (state == IDLE || state == CREDIT) &&
                    (coin_sum <= (CENTS_W+1)'(MAX_CREDIT));
        sel_take  = sel_valid && !cancel && (state == CREDIT) && sel_hit;

        coin_rej_nx = coin_valid && !coin_take;
        sel_deny_nx = sel_valid && !sel_take;

        case (state)
            IDLE: begin
                cfg_ok = 1'b1;
                if (coin_take) begin
                    credit_nx = coin_sum[CENTS_W-1:0];
                    state_nx  = CREDIT;
                end
            end
            CREDIT: begin
                if (cancel || timeout) begin
                    state_nx = CHANGE;
                end else if (sel_take) begin
                    credit_nx   = credit - sel_price;
                    vend_idx_nx = sel_idx;
                    state_nx    = VEND;
                end else if (coin_take) begin
                    credit_nx = coin_sum[CENTS_W-1:0];
                end
            end
            VEND: begin
                if (vend_ready) begin
                    vend_done = 1'b1;
                    state_nx  = (credit != '0) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                if (!chg_valid) begin
                    // Unpayable remainder (odd price) is kept by the machine.
                    credit_nx = '0;
                    state_nx  = IDLE;
                end else if (chg_ready) begin
                    credit_nx = credit - chg_val;
                    if (credit == chg_val)
                        state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            credit   <= '0;
            vend_idx <= '0;
            coin_rej <= 1'b0;
            sel_deny <= 1'b0;
            for (int i = 0; i < N_ITEMS; i++) begin
                price[i] <= '0;
                stock[i] <= STOCK_W'(STOCK_INIT);
            end
        end else begin
            state    <= state_nx;
            credit   <= credit_nx;
            vend_idx <= vend_idx_nx;
            coin_rej <= coin_rej_nx;
            sel_deny <= sel_deny_nx;
            // cfg_ok (IDLE) and vend_done (VEND) never coincide.
            for (int i = 0; i < N_ITEMS; i++) begin
                if (cfg_ok && cfg_we && cfg_idx == IW'(i))
                    price[i] <= cfg_price;
                if (cfg_ok && restock && cfg_idx == IW'(i))
                    stock[i] <= STOCK_W'(STOCK_INIT);
                else if (vend_done && vend_idx == IW'(i))
                    stock[i] <= stock[i] - STOCK_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller. Expected dispense slots and change
// coins are queued when a purchase/refund is triggered and popped when the
// DUT presents the matching handshake.
module tb_vend_controller;

    localparam int N  = 9;
    localparam int CW = 10;
    localparam int IW = 4;

    logic          clk, rst_n;
    logic          coin_valid, sel_valid, cancel, cfg_we, restock;
    logic [2:0]    coin_code;
    logic [IW-1:0] sel_idx, cfg_idx;
    logic [CW-1:0] cfg_price;
    logic          vend_valid, vend_ready, chg_valid, chg_ready;
    logic [IW-1:0] vend_idx;
    logic [2:0]    chg_code;
    logic [CW-1:0] credit;
    logic [N-1:0]  avail, oos;
    logic          coin_rej, sel_deny, busy;

    int errors = 0;
    int checks = 0;
    int vend_q[$];
    int chg_q[$];

    vend_controller #(
        .N_ITEMS(N), .CENTS_W(CW), .MAX_CREDIT(500),
        .STOCK_W(4), .STOCK_INIT(8), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .coin_valid(coin_valid), .coin_code(coin_code),
        .sel_valid(sel_valid), .sel_idx(sel_idx),
        .cancel(cancel), .cfg_we(cfg_we), .restock(restock),
        .cfg_idx(cfg_idx), .cfg_price(cfg_price),
        .vend_valid(vend_valid), .vend_idx(vend_idx), .vend_ready(vend_ready),
        .chg_valid(chg_valid), .chg_code(chg_code), .chg_ready(chg_ready),
        .credit(credit), .avail(avail), .oos(oos),
        .coin_rej(coin_rej), .sel_deny(sel_deny), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input int c);
        coin_code = 3'(c); coin_valid = 1'b1;
        cycle();
        coin_valid = 1'b0;
    endtask

    task automatic sel(input int i);
        sel_idx = IW'(i); sel_valid = 1'b1;
        cycle();
        sel_valid = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        cycle();
        cancel = 1'b0;
    endtask

    task automatic set_price(input int i, input int p);
        cfg_idx = IW'(i); cfg_price = CW'(p); cfg_we = 1'b1;
        cycle();
        cfg_we = 1'b0;
    endtask

    task automatic do_restock(input int i);
        cfg_idx = IW'(i); restock = 1'b1;
        cycle();
        restock = 1'b0;
    endtask

    task automatic vend_one();
        int n = 0;
        int e = -1;
        if (vend_q.size() > 0) e = vend_q.pop_front();
        while (!vend_valid && n < 50) begin cycle(); n++; end
        chk("vend_valid", 32'(vend_valid), 32'd1);
        chk("vend_idx", 32'(vend_idx), 32'(e));
        vend_ready = 1'b1;
        cycle();
        vend_ready = 1'b0;
    endtask

    task automatic chg_one();
        int n = 0;
        int e = -1;
        if (chg_q.size() > 0) e = chg_q.pop_front();
        while (!chg_valid && n < 50) begin cycle(); n++; end
        chk("chg_valid", 32'(chg_valid), 32'd1);
        chk("chg_code", 32'(chg_code), 32'(e));
        chg_ready = 1'b1;
        cycle();
        chg_ready = 1'b0;
    endtask

    task automatic chg_all();
        while (chg_q.size() > 0) chg_one();
    endtask

    initial begin
        rst_n = 1'b0; coin_valid = 0; coin_code = 0; sel_valid = 0; sel_idx = 0;
        cancel = 0; cfg_we = 0; restock = 0; cfg_idx = 0; cfg_price = 0;
        vend_ready = 0; chg_ready = 0;
        cycle(); cycle();
        chk("rst_credit", 32'(credit), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vend_valid", 32'(vend_valid), 32'd0);
        chk("rst_chg_valid", 32'(chg_valid), 32'd0);
        chk("rst_oos", 32'(oos), 32'h1FF);
        chk("rst_avail", 32'(avail), 32'd0);
        chk("rst_coin_rej", 32'(coin_rej), 32'd0);
        rst_n = 1'b1;
        cycle();

        // Exact payment: 25+25+50 for a 100-cent slot, no change.
        set_price(0, 100);
        chk("oos0_priced", 32'(oos[0]), 32'd0);
        coin(6);
        chk("bad_code_rej", 32'(coin_rej), 32'd1);
        chk("bad_code_credit", 32'(credit), 32'd0);
        coin(2); coin(2); coin(3);
        chk("exact_credit", 32'(credit), 32'd100);
        chk("exact_avail", 32'(avail), 32'h001);
        vend_q.push_back(0);
        sel(0);
        chk("exact_busy", 32'(busy), 32'd1);
        chk("exact_credit_after", 32'(credit), 32'd0);
        vend_one();
        chk("exact_idle", 32'(busy), 32'd0);
        chk("exact_no_chg", 32'(chg_valid), 32'd0);

        // 500 coin, 125 slot: change 100,100,100,50,25.
        set_price(2, 125);
        coin(5);
        chk("big_credit", 32'(credit), 32'd500);
        chk("big_avail", 32'(avail), 32'h005);
        vend_q.push_back(2);
        sel(2);
        chk("big_credit_vend", 32'(credit), 32'd375);
        vend_one();
        chk("big_in_change", 32'(busy), 32'd1);
        chg_q.push_back(4); chg_q.push_back(4); chg_q.push_back(4);
        chg_q.push_back(3); chg_q.push_back(2);
        chg_all();
        chk("big_credit_done", 32'(credit), 32'd0);
        chk("big_idle", 32'(busy), 32'd0);

        // Credit ceiling.
        coin(4); coin(4); coin(4); coin(4); coin(3); coin(2);
        chk("ceil_475", 32'(credit), 32'd475);
        coin(3);
        chk("ceil_rej", 32'(coin_rej), 32'd1);
        chk("ceil_hold", 32'(credit), 32'd475);
        cycle();
        chk("rej_pulse_one", 32'(coin_rej), 32'd0);
        coin(2);
        chk("ceil_500", 32'(credit), 32'd500);
        chk("ceil_accept", 32'(coin_rej), 32'd0);
        coin(0);
        chk("ceil_full_rej", 32'(coin_rej), 32'd1);

        // Unpriced and out-of-range selections.
        sel(1);
        chk("deny_unpriced", 32'(sel_deny), 32'd1);
        chk("deny_credit", 32'(credit), 32'd500);
        chk("deny_oos1", 32'(oos[1]), 32'd1);
        sel(9);
        chk("deny_range", 32'(sel_deny), 32'd1);
        do_cancel();
        for (int i = 0; i < 5; i++) chg_q.push_back(4);
        chg_all();
        chk("refund_idle", 32'(busy), 32'd0);

        // Drain slot 3 to zero stock, then reload.
        set_price(3, 5);
        for (int i = 0; i < 8; i++) begin
            coin(0);
            vend_q.push_back(3);
            sel(3);
            vend_one();
        end
        chk("empty_oos3", 32'(oos[3]), 32'd1);
        coin(0);
        sel(3);
        chk("empty_deny", 32'(sel_deny), 32'd1);
        chk("empty_credit", 32'(credit), 32'd5);
        set_price(4, 50);
        chk("cfg_ignored_credit", 32'(oos[4]), 32'd1);
        do_restock(3);
        chk("restock_ignored", 32'(oos[3]), 32'd1);
        do_cancel();
        chg_q.push_back(0);
        chg_all();
        do_restock(3);
        chk("restock_idle", 32'(oos[3]), 32'd0);

        // Cancel beats a same-cycle coin; hopper stall holds the code.
        coin(3); coin(1);
        chk("c60", 32'(credit), 32'd60);
        cancel = 1'b1; coin_valid = 1'b1; coin_code = 3'd0;
        cycle();
        cancel = 1'b0; coin_valid = 1'b0;
        chk("cancel_coin_rej", 32'(coin_rej), 32'd1);
        chk("cancel_credit", 32'(credit), 32'd60);
        chk("cancel_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_code", 32'(chg_code), 32'd3);
            chk("stall_valid", 32'(chg_valid), 32'd1);
        end
        chg_q.push_back(3); chg_q.push_back(1);
        chg_all();
        chk("c60_done", 32'(credit), 32'd0);
        chk("c60_idle", 32'(busy), 32'd0);

        // Inactivity in CREDIT, then reset in the middle of paying change.
        coin(2); coin(1);
        chk("c35", 32'(credit), 32'd35);
`ifdef VEND_TIMEOUT_EN
        repeat (15) cycle();
        chk("to_not_yet", 32'(busy), 32'd0);
        cycle();
        chk("to_fired", 32'(busy), 32'd1);
`else
        repeat (40) cycle();
        chk("no_timeout_busy", 32'(busy), 32'd0);
        chk("no_timeout_credit", 32'(credit), 32'd35);
        do_cancel();
`endif
        chg_q.push_back(2);
        chg_one();
        chk("mid_code", 32'(chg_code), 32'd1);
        chk("mid_credit", 32'(credit), 32'd10);
        rst_n = 1'b0;
        #1;
        chk("arst_credit", 32'(credit), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_chg_valid", 32'(chg_valid), 32'd0);
        chk("arst_oos", 32'(oos), 32'h1FF);
        cycle();
        rst_n = 1'b1;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
